// File: rtl/dat_read_seq_if.sv
// Control, status and data signals between the multi-block read sequencer and
// its surroundings (register file, dat_read receiver, host buffer).
interface dat_read_seq_if #(
   parameter int unsigned MaxBlockBitSize = 10,
   parameter int unsigned BufFreeWidth    = 10
);
   logic                       sd_clk_en_i;
   logic                       start_i;
   logic [MaxBlockBitSize-1:0] block_size_i;
   logic                       bus_width_is_4_i;
   logic [15:0]                block_count_i;
   logic                       block_count_en_i;
   logic [23:0]                timeout_i;
   logic                       abort_i;
   logic [BufFreeWidth-1:0]    buf_free_i;
   logic                       dat_start_o;
   logic [MaxBlockBitSize-1:0] dat_block_size_o;
   logic                       dat_bus_width_is_4_o;
   logic                       dat_rst_o;
   logic                       dat_data_valid_i;
   logic [31:0]                dat_data_i;
   logic                       dat_done_i;
   logic                       dat_crc_err_i;
   logic                       dat_end_bit_err_i;
   logic                       word_valid_o;
   logic [31:0]                word_o;
   logic                       sd_clk_stop_o;
   logic                       busy_o;
   logic [15:0]                blocks_left_o;
   logic                       block_done_o;
   logic                       xfer_done_o;
   logic                       crc_err_o;
   logic                       end_bit_err_o;
   logic                       timeout_err_o;

   modport slave (
      input  sd_clk_en_i, start_i, block_size_i, bus_width_is_4_i, block_count_i,
             block_count_en_i, timeout_i, abort_i, buf_free_i, dat_data_valid_i, dat_data_i,
             dat_done_i, dat_crc_err_i, dat_end_bit_err_i,
      output dat_start_o, dat_block_size_o, dat_bus_width_is_4_o, dat_rst_o, word_valid_o,
             word_o, sd_clk_stop_o, busy_o, blocks_left_o, block_done_o, xfer_done_o,
             crc_err_o, end_bit_err_o, timeout_err_o
   );

   modport master (
      output sd_clk_en_i, start_i, block_size_i, bus_width_is_4_i, block_count_i,
             block_count_en_i, timeout_i, abort_i, buf_free_i, dat_data_valid_i, dat_data_i,
             dat_done_i, dat_crc_err_i, dat_end_bit_err_i,
      input  dat_start_o, dat_block_size_o, dat_bus_width_is_4_o, dat_rst_o, word_valid_o,
             word_o, sd_clk_stop_o, busy_o, blocks_left_o, block_done_o, xfer_done_o,
             crc_err_o, end_bit_err_o, timeout_err_o
   );
endinterface

// File: rtl/dat_read_seq.sv
// Multi-block read sequencer: restarts dat_read per block, counts blocks, stops the SD
// clock while the host buffer lacks room for a block, forwards words and reports status.
module dat_read_seq #(
   parameter int unsigned MaxBlockBitSize = 10,
   parameter int unsigned BufFreeWidth    = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   dat_read_seq_if.slave bus
);
   localparam int unsigned NeedWidth = MaxBlockBitSize + 1;
   localparam int unsigned CmpWidth  = (NeedWidth > BufFreeWidth) ? NeedWidth : BufFreeWidth;

   typedef enum logic [2:0] {StIdle, StCheck, StStart, StWait, StGap} state_e;

   state_e                     r_state, w_state_next;
   logic [MaxBlockBitSize-1:0] r_block_size, w_block_size_next;
   logic                       r_bus_w4, w_bus_w4_next;
   logic                       r_count_en, w_count_en_next;
   logic [NeedWidth-1:0]       r_need, w_need_next;
   logic [15:0]                r_blocks_left, w_blocks_left_next;
   logic                       r_abort, w_abort_next;
   logic [23:0]                r_tmo_cnt, w_tmo_cnt_next;
   logic                       r_crc_err, w_crc_err_next;
   logic                       r_end_err, w_end_err_next;
   logic                       r_tmo_err, w_tmo_err_next;
   logic                       r_block_done, w_block_done_next;
   logic                       r_xfer_done, w_xfer_done_next;
   logic                       r_dat_rst, w_dat_rst_next;
   logic                       r_word_valid;
   logic [31:0]                r_word;

   logic [NeedWidth-1:0] w_size_ext;
   logic [NeedWidth-1:0] w_need_calc;
   logic                 w_space_ok;
   logic                 w_xfer_over;
   logic [23:0]          w_tmo_inc;
   logic                 w_tmo_hit;
   logic                 w_dat_err;

   assign w_size_ext  = NeedWidth'(bus.block_size_i);
   assign w_need_calc = (w_size_ext + NeedWidth'(3)) >> 2;
   assign w_space_ok  = CmpWidth'(bus.buf_free_i) >= CmpWidth'(r_need);
   assign w_xfer_over = (r_count_en && (r_blocks_left == 16'd0)) || r_abort;
   assign w_tmo_inc   = r_tmo_cnt + 24'd1;
   assign w_tmo_hit   = (bus.timeout_i != 24'd0) && bus.sd_clk_en_i &&
                        (w_tmo_inc >= bus.timeout_i);
   assign w_dat_err   = bus.dat_crc_err_i || bus.dat_end_bit_err_i;

   always_comb begin
      w_state_next       = r_state;
      w_block_size_next  = r_block_size;
      w_bus_w4_next      = r_bus_w4;
      w_count_en_next    = r_count_en;
      w_need_next        = r_need;
      w_blocks_left_next = r_blocks_left;
      w_abort_next       = r_abort || ((r_state != StIdle) && bus.abort_i);
      w_tmo_cnt_next     = r_tmo_cnt;
      w_crc_err_next     = r_crc_err;
      w_end_err_next     = r_end_err;
      w_tmo_err_next     = r_tmo_err;
      w_block_done_next  = 1'b0;
      w_xfer_done_next   = 1'b0;
      w_dat_rst_next     = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_abort_next = 1'b0;
            if (bus.start_i) begin
               w_block_size_next  = bus.block_size_i;
               w_bus_w4_next      = bus.bus_width_is_4_i;
               w_count_en_next    = bus.block_count_en_i;
               w_blocks_left_next = bus.block_count_i;
               w_need_next        = w_need_calc;
               w_crc_err_next     = 1'b0;
               w_end_err_next     = 1'b0;
               w_tmo_err_next     = 1'b0;
               w_state_next       = StCheck;
            end
         end
         StCheck: begin
            if (w_xfer_over) begin
               w_state_next     = StIdle;
               w_xfer_done_next = 1'b1;
               w_abort_next     = 1'b0;
            end else if (w_space_ok) begin
               w_state_next = StStart;
            end else begin
               w_state_next = StGap;
            end
         end
         StGap: begin
            if (w_space_ok || r_abort) w_state_next = StCheck;
         end
         StStart: begin
            w_tmo_cnt_next = 24'd0;
            if (bus.sd_clk_en_i) w_state_next = StWait;
         end
         StWait: begin
            if (bus.dat_done_i) begin
               if (w_dat_err) begin
                  // An error ends the transfer; a concurrent abort is dropped.
                  w_crc_err_next   = r_crc_err || bus.dat_crc_err_i;
                  w_end_err_next   = r_end_err || bus.dat_end_bit_err_i;
                  w_state_next     = StIdle;
                  w_xfer_done_next = 1'b1;
                  w_abort_next     = 1'b0;
               end else begin
                  if (r_count_en && (r_blocks_left != 16'd0)) begin
                     w_blocks_left_next = r_blocks_left - 16'd1;
                  end
                  w_block_done_next = 1'b1;
                  w_state_next      = StCheck;
               end
            end else if (w_tmo_hit) begin
               w_tmo_err_next   = 1'b1;
               w_dat_rst_next   = 1'b1;
               w_state_next     = StIdle;
               w_xfer_done_next = 1'b1;
               w_abort_next     = 1'b0;
            end else if (bus.sd_clk_en_i) begin
               w_tmo_cnt_next = w_tmo_inc;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= StIdle;
         r_block_size  <= '0;
         r_bus_w4      <= 1'b0;
         r_count_en    <= 1'b0;
         r_need        <= '0;
         r_blocks_left <= 16'd0;
         r_abort       <= 1'b0;
         r_tmo_cnt     <= 24'd0;
         r_crc_err     <= 1'b0;
         r_end_err     <= 1'b0;
         r_tmo_err     <= 1'b0;
         r_block_done  <= 1'b0;
         r_xfer_done   <= 1'b0;
         r_dat_rst     <= 1'b0;
         r_word_valid  <= 1'b0;
         r_word        <= 32'd0;
      end else begin
         r_state       <= w_state_next;
         r_block_size  <= w_block_size_next;
         r_bus_w4      <= w_bus_w4_next;
         r_count_en    <= w_count_en_next;
         r_need        <= w_need_next;
         r_blocks_left <= w_blocks_left_next;
         r_abort       <= w_abort_next;
         r_tmo_cnt     <= w_tmo_cnt_next;
         r_crc_err     <= w_crc_err_next;
         r_end_err     <= w_end_err_next;
         r_tmo_err     <= w_tmo_err_next;
         r_block_done  <= w_block_done_next;
         r_xfer_done   <= w_xfer_done_next;
         r_dat_rst     <= w_dat_rst_next;
         r_word_valid  <= bus.dat_data_valid_i;
         r_word        <= bus.dat_data_i;
      end
   end

   assign bus.dat_start_o          = (r_state == StStart);
   assign bus.sd_clk_stop_o        = (r_state == StGap);
   assign bus.busy_o               = (r_state != StIdle);
   assign bus.dat_block_size_o     = r_block_size;
   assign bus.dat_bus_width_is_4_o = r_bus_w4;
   assign bus.dat_rst_o            = r_dat_rst;
   assign bus.word_valid_o         = r_word_valid;
   assign bus.word_o               = r_word;
   assign bus.blocks_left_o        = r_blocks_left;
   assign bus.block_done_o         = r_block_done;
   assign bus.xfer_done_o          = r_xfer_done;
   assign bus.crc_err_o            = r_crc_err;
   assign bus.end_bit_err_o        = r_end_err;
   assign bus.timeout_err_o        = r_tmo_err;
endmodule

// File: tb/tb_dat_read_seq.sv
// Directed bench for dat_read_seq: emulates dat_read and the host buffer, checks each
// scenario inline against hand-computed values.
module tb_dat_read_seq;
   logic clk_i = 1'b0;
   logic rst_i;
   int   n_cmp = 0;
   int   n_bad = 0;

   dat_read_seq_if #(.MaxBlockBitSize(10), .BufFreeWidth(10)) bus ();

   dat_read_seq #(.MaxBlockBitSize(10), .BufFreeWidth(10)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // SD clock enable: one clk_i cycle in four.
   int en_div = 0;
   always begin
      @(posedge clk_i);
      #1;
      en_div = (en_div + 1) % 4;
      bus.sd_clk_en_i = (en_div == 0);
   end

   logic [31:0] word_q[$];
   logic [15:0] bl_q[$];
   int n_blkdone, n_xfer, n_acc, n_drst, n_stop, en_since, en_at_rst;

   always @(negedge clk_i) begin
      if (bus.word_valid_o) word_q.push_back(bus.word_o);
      if (bus.block_done_o) begin
         n_blkdone++;
         bl_q.push_back(bus.blocks_left_o);
      end
      if (bus.xfer_done_o) n_xfer++;
      if (bus.dat_start_o && bus.sd_clk_en_i) n_acc++;
      if (bus.dat_rst_o) begin
         n_drst++;
         en_at_rst = en_since;
      end
      if (bus.sd_clk_en_i) en_since++;
      if (bus.sd_clk_stop_o) n_stop++;
   end

   task automatic do_start(input logic [9:0] size, input logic w4, input logic [15:0] cnt,
                           input logic cnt_en, input logic [23:0] tmo, input logic [9:0] free);
      @(posedge clk_i);
      #1;
      word_q.delete();
      bl_q.delete();
      n_blkdone = 0; n_xfer = 0; n_acc = 0; n_drst = 0; n_stop = 0;
      bus.block_size_i = size;
      bus.bus_width_is_4_i = w4;
      bus.block_count_i = cnt;
      bus.block_count_en_i = cnt_en;
      bus.timeout_i = tmo;
      bus.buf_free_i = free;
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
   endtask

   task automatic wait_accept(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         if (bus.dat_start_o && bus.sd_clk_en_i) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_xfer(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk_i);
         #1;
         if (n_xfer > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Emulates dat_read delivering one block, then its done strobe.
   task automatic rx_block(input int nwords, input logic [31:0] base, input logic crc,
                           input logic ebe, input int abort_idx);
      for (int i = 0; i < nwords; i++) begin
         repeat (8) @(posedge clk_i);
         #1;
         bus.dat_data_valid_i = 1'b1;
         bus.dat_data_i = base + 32'(i);
         bus.abort_i = (i == abort_idx);
         @(posedge clk_i);
         #1;
         bus.dat_data_valid_i = 1'b0;
         bus.abort_i = 1'b0;
      end
      repeat (3) @(posedge clk_i);
      #1;
      bus.dat_done_i = 1'b1;
      bus.dat_crc_err_i = crc;
      bus.dat_end_bit_err_i = ebe;
      @(posedge clk_i);
      #1;
      bus.dat_done_i = 1'b0;
      bus.dat_crc_err_i = 1'b0;
      bus.dat_end_bit_err_i = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk_i);
      n_cmp++;
      if (bus.busy_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o);
      end
      n_cmp++;
      if (bus.blocks_left_o !== 16'd0) begin
         n_bad++; $display("FAIL reset_blocks_left: got %0d want 0", bus.blocks_left_o);
      end
      n_cmp++;
      if (bus.dat_block_size_o !== 10'd0) begin
         n_bad++; $display("FAIL reset_block_size: got %0d want 0", bus.dat_block_size_o);
      end
      n_cmp++;
      if ({bus.dat_start_o, bus.dat_rst_o, bus.sd_clk_stop_o, bus.word_valid_o,
           bus.block_done_o, bus.xfer_done_o, bus.crc_err_o, bus.end_bit_err_o,
           bus.timeout_err_o, bus.dat_bus_width_is_4_o} !== 10'd0) begin
         n_bad++; $display("FAIL reset_flags: some 1-bit output nonzero, want all 0");
      end
      n_cmp++;
      if (bus.word_o !== 32'd0) begin
         n_bad++; $display("FAIL reset_word: got %h want 0", bus.word_o);
      end
   endtask

   task automatic test_word_latency;
      @(posedge clk_i);
      #1;
      bus.dat_data_valid_i = 1'b1;
      bus.dat_data_i = 32'h1234_5678;
      @(negedge clk_i);
      n_cmp++;
      if (bus.word_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL lat_early: got %b want 0", bus.word_valid_o);
      end
      @(posedge clk_i);
      #1;
      bus.dat_data_valid_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({bus.word_valid_o, bus.word_o} !== {1'b1, 32'h1234_5678}) begin
         n_bad++; $display("FAIL lat_word: got %b/%h want 1/12345678", bus.word_valid_o,
                           bus.word_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if (bus.word_valid_o !== 1'b0) begin
         n_bad++; $display("FAIL lat_single: got %b want 0", bus.word_valid_o);
      end
   endtask

   task automatic test_multi_block;
      bit ok;
      do_start(10'd512, 1'b0, 16'd3, 1'b1, 24'd0, 10'd128);
      @(negedge clk_i);
      n_cmp++;
      if ({bus.busy_o, bus.blocks_left_o} !== {1'b1, 16'd3}) begin
         n_bad++; $display("FAIL mb_start: busy/left %b/%0d want 1/3", bus.busy_o,
                           bus.blocks_left_o);
      end
      for (int b = 0; b < 3; b++) begin
         wait_accept(ok);
         n_cmp++;
         if (ok !== 1'b1) begin
            n_bad++; $display("FAIL mb_accept: block %0d start got 0 want 1", b);
         end
         rx_block(128, 32'hA000_0000 + (32'(b) << 16), 1'b0, 1'b0, -1);
      end
      wait_xfer(ok);
      n_cmp++;
      if (ok !== 1'b1) begin
         n_bad++; $display("FAIL mb_xfer_done: got 0 want 1");
      end
      n_cmp++;
      if (word_q.size() != 384) begin
         n_bad++; $display("FAIL mb_word_count: got %0d want 384", word_q.size());
      end
      for (int i = 0; i < word_q.size(); i++) begin
         logic [31:0] exp_w;
         exp_w = 32'hA000_0000 + (32'(i / 128) << 16) + 32'(i % 128);
         n_cmp++;
         if (word_q[i] !== exp_w) begin
            n_bad++; $display("FAIL mb_word[%0d]: got %h want %h", i, word_q[i], exp_w);
         end
      end
      n_cmp++;
      if (n_blkdone != 3 || bl_q.size() != 3) begin
         n_bad++; $display("FAIL mb_block_done: got %0d want 3", n_blkdone);
      end else begin
         n_cmp++;
         if ({bl_q[0], bl_q[1], bl_q[2]} !== {16'd2, 16'd1, 16'd0}) begin
            n_bad++; $display("FAIL mb_left_steps: got %0d,%0d,%0d want 2,1,0", bl_q[0],
                              bl_q[1], bl_q[2]);
         end
      end
      n_cmp++;
      if (n_acc != 3 || n_stop != 0 || n_xfer != 1 || bus.busy_o !== 1'b0) begin
         n_bad++; $display("FAIL mb_counts: acc/stop/xfer/busy %0d/%0d/%0d/%b want 3/0/1/0",
                           n_acc, n_stop, n_xfer, bus.busy_o);
      end
   endtask

   task automatic test_gap;
      bit ok;
      do_start(10'd6, 1'b1, 16'd2, 1'b1, 24'd0, 10'd1);
      repeat (20) @(negedge clk_i);
      n_cmp++;
      if ({bus.sd_clk_stop_o, bus.dat_start_o} !== 2'b10 || n_acc != 0) begin
         n_bad++; $display("FAIL gap_stop: stop/start/acc %b/%b/%0d want 1/0/0",
                           bus.sd_clk_stop_o, bus.dat_start_o, n_acc);
      end
      n_cmp++;
      if ({bus.dat_bus_width_is_4_o, bus.dat_block_size_o} !== {1'b1, 10'd6}) begin
         n_bad++; $display("FAIL gap_cfg: w4/size %b/%0d want 1/6", bus.dat_bus_width_is_4_o,
                           bus.dat_block_size_o);
      end
      @(posedge clk_i);
      #1;
      bus.buf_free_i = 10'd2;
      for (int b = 0; b < 2; b++) begin
         wait_accept(ok);
         n_cmp++;
         if ({ok, bus.sd_clk_stop_o} !== 2'b10) begin
            n_bad++; $display("FAIL gap_release: block %0d ok/stop %b/%b want 1/0", b, ok,
                              bus.sd_clk_stop_o);
         end
         rx_block(2, 32'hB000_0000 + (32'(b) << 8), 1'b0, 1'b0, -1);
      end
      wait_xfer(ok);
      n_cmp++;
      if (ok !== 1'b1 || word_q.size() != 4) begin
         n_bad++; $display("FAIL gap_done: xfer/words %b/%0d want 1/4", ok, word_q.size());
      end else begin
         n_cmp++;
         if ({word_q[0], word_q[1], word_q[2], word_q[3]} !==
             {32'hB000_0000, 32'hB000_0001, 32'hB000_0100, 32'hB000_0101}) begin
            n_bad++; $display("FAIL gap_words: got %h %h %h %h want B0000000 B0000001 %s",
                              word_q[0], word_q[1], word_q[2], word_q[3],
                              "B0000100 B0000101");
         end
      end
   endtask

   task automatic test_abort;
      bit ok;
      do_start(10'd8, 1'b0, 16'd5, 1'b0, 24'd0, 10'd128);
      for (int b = 0; b < 2; b++) begin
         wait_accept(ok);
         n_cmp++;
         if (ok !== 1'b1) begin
            n_bad++; $display("FAIL ab_accept: block %0d got 0 want 1", b);
         end
         rx_block(2, 32'hC000_0000 + (32'(b) << 8), 1'b0, 1'b0, (b == 1) ? 0 : -1);
      end
      wait_xfer(ok);
      n_cmp++;
      if (ok !== 1'b1 || word_q.size() != 4) begin
         n_bad++; $display("FAIL ab_done: xfer/words %b/%0d want 1/4", ok, word_q.size());
      end else begin
         n_cmp++;
         if (word_q[3] !== 32'hC000_0101) begin
            n_bad++; $display("FAIL ab_last_word: got %h want C0000101", word_q[3]);
         end
      end
      n_cmp++;
      if (bus.blocks_left_o !== 16'd5 || n_blkdone != 2 || n_acc != 2) begin
         n_bad++; $display("FAIL ab_counts: left/bd/acc %0d/%0d/%0d want 5/2/2",
                           bus.blocks_left_o, n_blkdone, n_acc);
      end
   endtask

   task automatic test_crc_err;
      bit ok;
      do_start(10'd8, 1'b0, 16'd4, 1'b1, 24'd0, 10'd128);
      wait_accept(ok);
      rx_block(2, 32'hD000_0000, 1'b1, 1'b0, -1);
      wait_xfer(ok);
      n_cmp++;
      if ({ok, bus.crc_err_o, bus.end_bit_err_o} !== 3'b110) begin
         n_bad++; $display("FAIL crc_flags: xfer/crc/ebe %b/%b/%b want 1/1/0", ok,
                           bus.crc_err_o, bus.end_bit_err_o);
      end
      repeat (40) @(negedge clk_i);
      n_cmp++;
      if (n_acc != 1 || n_blkdone != 0 || bus.blocks_left_o !== 16'd4) begin
         n_bad++; $display("FAIL crc_stop: acc/bd/left %0d/%0d/%0d want 1/0/4", n_acc,
                           n_blkdone, bus.blocks_left_o);
      end
      n_cmp++;
      if ({bus.crc_err_o, bus.busy_o} !== 2'b10) begin
         n_bad++; $display("FAIL crc_sticky: crc/busy %b/%b want 1/0", bus.crc_err_o,
                           bus.busy_o);
      end
   endtask

   task automatic test_count_zero;
      do_start(10'd8, 1'b0, 16'd0, 1'b1, 24'd0, 10'd128);
      @(negedge clk_i);
      n_cmp++;
      if ({bus.xfer_done_o, bus.busy_o, bus.crc_err_o} !== 3'b010) begin
         n_bad++; $display("FAIL cz_cycle1: xfer/busy/crc %b/%b/%b want 0/1/0",
                           bus.xfer_done_o, bus.busy_o, bus.crc_err_o);
      end
      @(negedge clk_i);
      n_cmp++;
      if ({bus.xfer_done_o, bus.busy_o} !== 2'b10) begin
         n_bad++; $display("FAIL cz_cycle2: xfer/busy %b/%b want 1/0", bus.xfer_done_o,
                           bus.busy_o);
      end
      repeat (10) @(negedge clk_i);
      n_cmp++;
      if (n_acc != 0 || n_xfer != 1) begin
         n_bad++; $display("FAIL cz_counts: acc/xfer %0d/%0d want 0/1", n_acc, n_xfer);
      end
   endtask

   task automatic test_timeout;
      bit ok;
      do_start(10'd8, 1'b0, 16'd1, 1'b1, 24'd100, 10'd128);
      wait_accept(ok);
      #1;
      en_since = 0;
      for (int i = 0; i < 1000 && n_drst == 0; i++) @(negedge clk_i);
      repeat (5) @(negedge clk_i);
      n_cmp++;
      if (n_drst != 1 || en_at_rst != 100) begin
         n_bad++; $display("FAIL to_rst: pulses/sd_clks %0d/%0d want 1/100", n_drst,
                           en_at_rst);
      end
      n_cmp++;
      if ({bus.timeout_err_o, bus.busy_o} !== 2'b10 || n_xfer != 1) begin
         n_bad++; $display("FAIL to_flags: tmo/busy/xfer %b/%b/%0d want 1/0/1",
                           bus.timeout_err_o, bus.busy_o, n_xfer);
      end
   endtask

   task automatic test_rst_in_wait;
      bit ok;
      do_start(10'd8, 1'b1, 16'd3, 1'b1, 24'd0, 10'd128);
      wait_accept(ok);
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      n_cmp++;
      if ({bus.busy_o, bus.dat_start_o, bus.sd_clk_stop_o, bus.dat_bus_width_is_4_o,
           bus.timeout_err_o} !== 5'd0) begin
         n_bad++; $display("FAIL rst_flags: busy/start/stop/w4/tmo %b%b%b%b%b want 00000",
                           bus.busy_o, bus.dat_start_o, bus.sd_clk_stop_o,
                           bus.dat_bus_width_is_4_o, bus.timeout_err_o);
      end
      n_cmp++;
      if ({bus.blocks_left_o, bus.dat_block_size_o} !== 26'd0) begin
         n_bad++; $display("FAIL rst_regs: left/size %0d/%0d want 0/0", bus.blocks_left_o,
                           bus.dat_block_size_o);
      end
      repeat (5) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (5) @(negedge clk_i);
      n_cmp++;
      if (n_xfer != 0 || bus.busy_o !== 1'b0) begin
         n_bad++; $display("FAIL rst_no_done: xfer/busy %0d/%b want 0/0", n_xfer, bus.busy_o);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      bus.start_i = 1'b0;
      bus.block_size_i = '0;
      bus.bus_width_is_4_i = 1'b0;
      bus.block_count_i = '0;
      bus.block_count_en_i = 1'b0;
      bus.timeout_i = '0;
      bus.abort_i = 1'b0;
      bus.buf_free_i = '0;
      bus.dat_data_valid_i = 1'b0;
      bus.dat_data_i = '0;
      bus.dat_done_i = 1'b0;
      bus.dat_crc_err_i = 1'b0;
      bus.dat_end_bit_err_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      test_reset();
      test_word_latency();
      test_multi_block();
      test_gap();
      test_abort();
      test_crc_err();
      test_count_zero();
      test_timeout();
      test_rst_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dat_read_seq.md
# dat_read_seq

Multi-block read transfer sequencer for the SD data receive path. It starts and restarts the `dat_read` receiver once per block and counts blocks. It stops the SD clock at block gaps when the host buffer cannot take a whole block. It also registers received words toward the buffer, enforces a data timeout and reports completion and error status to the register file.

## Interface
- `MaxBlockBitSize`, 10: width of block size in bytes; must match `dat_read`.
- `BufFreeWidth`, 10: width of the buffer free-space count, in 32-bit words.
- `clk_i` in 1: system clock; the block's only clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `sd_clk_en_i` in 1: SD clock enable strobe, the same strobe `dat_read` uses.
- `start_i` in 1: one-cycle transfer request; ignored while `busy_o`=1.
- `block_size_i` in MaxBlockBitSize: bytes per block; latched on start.
- `bus_width_is_4_i` in 1: latched on start.
- `block_count_i` in 16: blocks to read; latched on start.
- `block_count_en_i` in 1: 0 = unbounded transfer, ended only by abort or error.
- `timeout_i` in 24: SD clocks allowed per block; 0 disables the timeout.
- `abort_i` in 1: stop request, e.g. CMD12 issued.
- `buf_free_i` in BufFreeWidth: free words in the host buffer.
- `dat_start_o` out 1, `dat_block_size_o` out MaxBlockBitSize, `dat_bus_width_is_4_o` out 1: receiver control.
- `dat_rst_o` out 1: one-cycle receiver reset, active-high; the integrator inverts it into `dat_read` reset.
- `dat_data_valid_i` in 1, `dat_data_i` in 32, `dat_done_i` in 1, `dat_crc_err_i` in 1, `dat_end_bit_err_i` in 1: receiver outputs.
- `word_valid_o` out 1, `word_o` out 32: buffer write port; there is no back-pressure.
- `sd_clk_stop_o` out 1: request to gate the SD card clock (read wait).
- `busy_o` out 1, `blocks_left_o` out 16, `block_done_o` out 1, `xfer_done_o` out 1.
- `crc_err_o`, `end_bit_err_o`, `timeout_err_o` out 1 each: sticky status flags.

## Operation
- States: IDLE, CHECK, START, WAIT, GAP.
- IDLE → CHECK on `start_i`:
  - Latch the configuration and clear all sticky flags.
  - `blocks_left_o` takes `block_count_i`.
  - Compute `need` = (block_size+3)>>2 words.
- CHECK, evaluated each clk_i cycle:
  - Transfer is over if `block_count_en_i` is set and `blocks_left_o`=0, or an abort is latched. Then finish: go to IDLE and pulse `xfer_done_o`.
  - Else if `buf_free_i` ≥ `need`, go to START.
  - Else go to GAP.
- GAP:
  - `sd_clk_stop_o`=1.
  - Return to CHECK when space is available or an abort is latched.
- START:
  - `dat_start_o`=1.
  - Go to WAIT on the first cycle with `sd_clk_en_i`=1; that is the cycle `dat_read` accepts the start.
- WAIT:
  - Count `sd_clk_en_i` cycles.
  - On `dat_done_i` with no error flags: decrement `blocks_left_o` (when count enabled), pulse `block_done_o`, then go to CHECK.
  - On `dat_done_i` with `dat_crc_err_i` or `dat_end_bit_err_i`: set the matching sticky flag(s) and finish.
  - If the counter reaches `timeout_i` (nonzero) before `dat_done_i`: set `timeout_err_o`, pulse `dat_rst_o` and finish.
- `abort_i` is latched in any non-IDLE state. It takes effect only at block boundaries (CHECK or GAP), so an in-flight block always completes and all of its words are delivered.
- Word path: `word_valid_o` and `word_o` are `dat_data_valid_i` and `dat_data_i` registered once. They are forwarded in every state.
- `busy_o`=1 in every state except IDLE.

## Timing
- Reset values:
  - State IDLE; all counters 0.
  - `dat_block_size_o`=0; every other output 0.
- Word latency is exactly 1 clk_i cycle. The source guarantees at least 7 cycles between words; the CHECK space test guarantees the buffer can take them.
- Block restart: `dat_done_i` (cycle n) → CHECK (n+1) → START (n+2). START holds until the next `sd_clk_en_i`, so `dat_read` re-enters READY one SD clock after the end bit. This meets Nac ≥ 2.
- `sd_clk_stop_o` rises no later than clk_i cycle n+2 after `dat_done_i` and before any further `sd_clk_en_i`.
- Timeout counts only while in WAIT and only on `sd_clk_en_i` cycles; it resets on entering START.
- Edge cases:
  - `block_count_en_i`=1 with `block_count_i`=0: no `dat_start_o`; `xfer_done_o` 2 cycles after `start_i`.
  - `blocks_left_o` never wraps below 0.
  - When count is disabled, `blocks_left_o` holds its latched value.
  - Error and `abort_i` in the same cycle: the error is reported and abort is discarded.
  - `rst_i` mid-transfer: immediate return to reset values; no `xfer_done_o`.

## Test plan
- 1-bit bus, size 512, count 3, buffer always 128 free → 384 words in order, 3 `block_done_o` pulses, then `xfer_done_o`, with `blocks_left_o` stepping 3→2→1→0.
- 4-bit bus, size 6, count 2, buffer free 1 → GAP with `sd_clk_stop_o`=1, no `dat_start_o`. Raising free to 2 releases the stop; 2 words per block are delivered.
- Count disabled, `abort_i` pulsed mid-block 2 → block 2 completes with all its words, then `xfer_done_o`; `blocks_left_o` unchanged.
- CRC-bad block 1 of 4 → `crc_err_o`=1 and `xfer_done_o`; no second `dat_start_o`; the flag stays set until the next `start_i`.
- `timeout_i`=100 with no start bit driven → after 100 SD clocks `timeout_err_o`=1, one `dat_rst_o` pulse, then `xfer_done_o`.
- Count 0 with enable → `xfer_done_o` 2 cycles after `start_i`; `rst_i` asserted in WAIT → all outputs 0 at once.
